// File: rtl/plab4_net_sd_pkg.sv
// Shared sizing helpers and default scheduler settings for the
// security-domain-partitioned router input port.
package plab4_net_sd_pkg;

  localparam int c_default_slot_cycles = 1;
  localparam int c_default_dead_cycles = 0;

  // Bit width needed to index n items, never less than one bit.
  function automatic int nbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plab4_net_sd_sched.sv
// Time-slot scheduler: rotates dequeue ownership across domains and marks
// the dead window at the tail of every slot.
module plab4_net_sd_sched
  import plab4_net_sd_pkg::*;
#(
  parameter int p_num_domains = 2,
  parameter int p_slot_cycles = c_default_slot_cycles,
  parameter int p_dead_cycles = c_default_dead_cycles,
  parameter int c_sd_nbits    = nbits(p_num_domains)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [c_sd_nbits-1:0] cur_sd,
  output logic                  slot_last,
  output logic                  dead
);

  localparam int c_slot_nbits = nbits(p_slot_cycles);

  logic [c_slot_nbits-1:0] slot_cnt_q, slot_cnt_d;
  logic [c_sd_nbits-1:0]   cur_sd_q, cur_sd_d;

  assign slot_last = (slot_cnt_q == c_slot_nbits'(p_slot_cycles - 1));
  assign dead      = (32'(slot_cnt_q) >= 32'(p_slot_cycles - p_dead_cycles));
  assign cur_sd    = cur_sd_q;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    slot_cnt_d = slot_cnt_q + c_slot_nbits'(1);
    cur_sd_d   = cur_sd_q;
    if (slot_last) begin
      slot_cnt_d = '0;
      cur_sd_d   = (cur_sd_q == c_sd_nbits'(p_num_domains - 1))
                   ? '0 : cur_sd_q + c_sd_nbits'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_cnt_q <= '0;
      cur_sd_q   <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      cur_sd_q   <= cur_sd_d;
    end
  end

endmodule

// File: rtl/plab4_net_sd_input_port.sv
// Router input port with one FIFO per security domain; enqueue is steered by
// in_sd, dequeue is owned by the scheduled domain only.
module plab4_net_sd_input_port
  import plab4_net_sd_pkg::*;
#(
  parameter int p_msg_nbits   = 44,
  parameter int p_num_domains = 2,
  parameter int p_num_msgs    = 4,
  parameter int p_slot_cycles = c_default_slot_cycles,
  parameter int p_dead_cycles = c_default_dead_cycles,
  parameter int c_sd_nbits    = nbits(p_num_domains),
  parameter int c_cnt_nbits   = $clog2(p_num_msgs + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  input  logic [c_sd_nbits-1:0]  in_sd,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic [c_sd_nbits-1:0]  cur_sd,
  output logic [c_cnt_nbits-1:0] num_free,
  output logic                   slot_last
);

  localparam int c_ptr_nbits = nbits(p_num_msgs);

  logic [p_num_domains-1:0] fifo_full;
  logic [p_num_domains-1:0] fifo_empty;
  logic [c_cnt_nbits-1:0]   fifo_cnt  [p_num_domains];
  logic [p_msg_nbits-1:0]   fifo_head [p_num_domains];

  logic                   dead;
  logic                   in_sd_ok;
  logic                   in_full;
  logic                   cur_empty;
  logic [c_cnt_nbits-1:0] cur_cnt;
  logic                   enq_fire;
  logic                   deq_fire;

  plab4_net_sd_sched #(
    .p_num_domains (p_num_domains),
    .p_slot_cycles (p_slot_cycles),
    .p_dead_cycles (p_dead_cycles),
    .c_sd_nbits    (c_sd_nbits)
  ) u_sched (
    .clk       (clk),
    .reset     (reset),
    .cur_sd    (cur_sd),
    .slot_last (slot_last),
    .dead      (dead)
  );

  // Two independent selectors keep in_rdy tied to FIFO[in_sd] and every
  // dequeue-side output tied to FIFO[cur_sd] only.
  always_comb begin
    in_sd_ok  = 1'b0;
    in_full   = 1'b1;
    cur_empty = 1'b1;
    cur_cnt   = '0;
    deq_msg   = '0;
    for (int d = 0; d < p_num_domains; d++) begin
      if (in_sd == c_sd_nbits'(d)) begin
        in_sd_ok = 1'b1;
        in_full  = fifo_full[d];
      end
      if (cur_sd == c_sd_nbits'(d)) begin
        cur_empty = fifo_empty[d];
        cur_cnt   = fifo_cnt[d];
        deq_msg   = fifo_head[d];
      end
    end
  end

  assign in_rdy   = reset & in_sd_ok & ~in_full;
  assign deq_val  = reset & ~cur_empty & ~dead;
  assign enq_fire = in_val & in_rdy;
  assign deq_fire = deq_val & deq_rdy;
  assign num_free = c_cnt_nbits'(p_num_msgs) - cur_cnt;

  for (genvar d = 0; d < p_num_domains; d++) begin : g_fifo
    logic [p_msg_nbits-1:0] mem_q [p_num_msgs];
    logic [c_ptr_nbits-1:0] head_q, tail_q;
    logic [c_cnt_nbits-1:0] cnt_q;
    logic                   enq, deq;

    assign enq = enq_fire & (in_sd == c_sd_nbits'(d));
    assign deq = deq_fire & (cur_sd == c_sd_nbits'(d));

    assign fifo_full[d]  = (cnt_q == c_cnt_nbits'(p_num_msgs));
    assign fifo_empty[d] = (cnt_q == '0);
    assign fifo_cnt[d]   = cnt_q;
    assign fifo_head[d]  = mem_q[head_q];

    always_ff @(posedge clk) begin
      if (!reset) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (enq)
          tail_q <= (tail_q == c_ptr_nbits'(p_num_msgs - 1))
                    ? '0 : tail_q + c_ptr_nbits'(1);
        if (deq)
          head_q <= (head_q == c_ptr_nbits'(p_num_msgs - 1))
                    ? '0 : head_q + c_ptr_nbits'(1);
        case ({enq, deq})
          2'b10:   cnt_q <= cnt_q + c_cnt_nbits'(1);
          2'b01:   cnt_q <= cnt_q - c_cnt_nbits'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    // NOTE: storage is not reset; occupancy comes only from the counters.
    always_ff @(posedge clk) begin
      if (enq) mem_q[tail_q] <= in_msg;
    end
  end

endmodule

// File: tb/tb_plab4_net_sd_input_port.sv
// Self-checking bench: two configurations in lockstep against a queue-level
// model, plus a hand-computed vector table and directed corner sequences.
module tb_plab4_net_sd_input_port;

  localparam int MW = 44;

  typedef struct packed {
    logic          rst;
    logic          val;
    logic [1:0]    sd;
    logic [MW-1:0] msg;
    logic          rdy;
  } stim_t;

  typedef struct packed {
    logic          in_rdy;
    logic          deq_val;
    logic [MW-1:0] msg;
    logic [1:0]    cur_sd;
    logic [2:0]    num_free;
    logic          slot_last;
  } out_t;

  typedef struct {
    stim_t         s;
    logic          in_rdy;
    logic          deq_val;
    logic [1:0]    cur_sd;
    logic [2:0]    num_free;
    logic [MW-1:0] msg;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t sa, sb;

  logic          a_in_rdy, a_deq_val, a_cur_sd, a_slot_last;
  logic [MW-1:0] a_deq_msg;
  logic [2:0]    a_num_free;
  logic          b_in_rdy, b_deq_val, b_slot_last;
  logic [1:0]    b_cur_sd;
  logic [MW-1:0] b_deq_msg;
  logic [2:0]    b_num_free;

  plab4_net_sd_input_port #(
    .p_msg_nbits(MW), .p_num_domains(2), .p_num_msgs(4),
    .p_slot_cycles(1), .p_dead_cycles(0)
  ) dut_a (
    .clk(clk), .reset(sa.rst), .in_val(sa.val), .in_rdy(a_in_rdy),
    .in_msg(sa.msg), .in_sd(sa.sd[0]), .deq_val(a_deq_val), .deq_rdy(sa.rdy),
    .deq_msg(a_deq_msg), .cur_sd(a_cur_sd), .num_free(a_num_free),
    .slot_last(a_slot_last)
  );

  plab4_net_sd_input_port #(
    .p_msg_nbits(MW), .p_num_domains(3), .p_num_msgs(4),
    .p_slot_cycles(4), .p_dead_cycles(1)
  ) dut_b (
    .clk(clk), .reset(sb.rst), .in_val(sb.val), .in_rdy(b_in_rdy),
    .in_msg(sb.msg), .in_sd(sb.sd), .deq_val(b_deq_val), .deq_rdy(sb.rdy),
    .deq_msg(b_deq_msg), .cur_sd(b_cur_sd), .num_free(b_num_free),
    .slot_last(b_slot_last)
  );

  // Reference model: per-instance domain count, slot length, dead cycles,
  // message arrays (head at index 0) and cycles since reset release.
  int            pn [2] = '{2, 3};
  int            ps [2] = '{1, 4};
  int            pd [2] = '{0, 1};
  logic [MW-1:0] mq [2][3][4];
  int            mc [2][3];
  int            mt [2];
  bit            live = 1'b0;

  int   total = 0;
  int   bad   = 0;
  out_t oa, ob;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input bit rst, input bit val, input int sd,
                               input logic [MW-1:0] msg, input bit rdy);
    stim_t s;
    s.rst = rst;
    s.val = val;
    s.sd  = sd[1:0];
    s.msg = msg;
    s.rdy = rdy;
    return s;
  endfunction

  function automatic stim_t rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return mk($urandom_range(0, 63) != 0, $urandom_range(0, 2) != 0,
              int'($urandom_range(0, 3)), r[MW-1:0], $urandom_range(0, 3) != 0);
  endfunction

  function automatic void expect_of(input int m, input stim_t s, output bit ev,
                                    output bit er, output int sd, output int isd);
    int sc;
    sd  = (mt[m] / ps[m]) % pn[m];
    sc  = mt[m] % ps[m];
    isd = (m == 0) ? int'(s.sd[0]) : int'(s.sd);
    ev  = s.rst && (mc[m][sd] > 0) && (sc < ps[m] - pd[m]);
    er  = s.rst && (isd < pn[m]) && (mc[m][isd] < 4);
  endfunction

  task automatic model_check(input int m, input stim_t s, input out_t o);
    bit ev, er;
    int sd, isd, sc;
    expect_of(m, s, ev, er, sd, isd);
    sc = mt[m] % ps[m];
    check($sformatf("m%0d.cur_sd", m), 64'(o.cur_sd), 64'(sd));
    check($sformatf("m%0d.slot_last", m), 64'(o.slot_last), 64'(sc == ps[m] - 1));
    check($sformatf("m%0d.deq_val", m), 64'(o.deq_val), 64'(ev));
    check($sformatf("m%0d.in_rdy", m), 64'(o.in_rdy), 64'(er));
    check($sformatf("m%0d.num_free", m), 64'(o.num_free), 64'(4 - mc[m][sd]));
    if (ev) check($sformatf("m%0d.deq_msg", m), 64'(o.msg), 64'(mq[m][sd][0]));
  endtask

  task automatic model_update(input int m, input stim_t s);
    bit ev, er;
    int sd, isd;
    expect_of(m, s, ev, er, sd, isd);
    if (!s.rst) begin
      for (int d = 0; d < 3; d++) mc[m][d] = 0;
      mt[m] = 0;
    end else begin
      if (ev && s.rdy) begin
        for (int k = 0; k < 3; k++) mq[m][sd][k] = mq[m][sd][k+1];
        mc[m][sd]--;
      end
      if (s.val && er) begin
        mq[m][isd][mc[m][isd]] = s.msg;
        mc[m][isd]++;
      end
      mt[m]++;
    end
  endtask

  task automatic step(input stim_t a, input stim_t b);
    sa = a;
    sb = b;
    @(negedge clk);
    oa.in_rdy = a_in_rdy;  oa.deq_val = a_deq_val;  oa.msg = a_deq_msg;
    oa.cur_sd = {1'b0, a_cur_sd};  oa.num_free = a_num_free;  oa.slot_last = a_slot_last;
    ob.in_rdy = b_in_rdy;  ob.deq_val = b_deq_val;  ob.msg = b_deq_msg;
    ob.cur_sd = b_cur_sd;  ob.num_free = b_num_free;  ob.slot_last = b_slot_last;
    if (live) begin
      model_check(0, a, oa);
      model_check(1, b, ob);
    end
    @(posedge clk);
    model_update(0, a);
    model_update(1, b);
    live = 1'b1;
    #1;
  endtask

  task automatic align_b(input stim_t a_idle, input stim_t b_idle);
    for (int g = 0; g < 12 && (mt[1] % 12) != 0; g++) step(a_idle, b_idle);
  endtask

  function automatic vec_t mkv(input stim_t s, input bit r, input bit v, input int sd,
                               input int nf, input logic [MW-1:0] msg);
    vec_t x;
    x.s = s;  x.in_rdy = r;  x.deq_val = v;
    x.cur_sd = sd[1:0];  x.num_free = nf[2:0];  x.msg = msg;
    return x;
  endfunction

  vec_t  tbl [$];
  stim_t idle;
  int    pops;

  initial begin
    idle = mk(1, 0, 0, '0, 0);

    // Hand-derived vectors for the 2-domain, slot=1 instance.
    tbl.push_back(mkv(mk(0, 1, 1, MW'('hA), 0), 0, 0, 0, 4, '0));
    tbl.push_back(mkv(mk(0, 1, 1, MW'('hA), 0), 0, 0, 0, 4, '0));
    tbl.push_back(mkv(mk(1, 0, 0, '0, 0),       1, 0, 0, 4, '0));
    tbl.push_back(mkv(mk(1, 0, 0, '0, 0),       1, 0, 1, 4, '0));
    tbl.push_back(mkv(mk(1, 0, 0, '0, 0),       1, 0, 0, 4, '0));
    tbl.push_back(mkv(mk(1, 1, 1, MW'('hA), 0), 1, 0, 1, 4, '0));
    tbl.push_back(mkv(mk(1, 1, 1, MW'('hB), 0), 1, 0, 0, 4, '0));
    tbl.push_back(mkv(mk(1, 1, 1, MW'('hC), 0), 1, 1, 1, 2, MW'('hA)));
    tbl.push_back(mkv(mk(1, 1, 1, MW'('hD), 0), 1, 0, 0, 4, '0));
    tbl.push_back(mkv(mk(1, 1, 1, MW'('hE), 0), 0, 1, 1, 0, MW'('hA)));
    tbl.push_back(mkv(mk(1, 0, 0, '0, 0),       1, 0, 0, 4, '0));
    tbl.push_back(mkv(mk(1, 0, 1, '0, 1),       0, 1, 1, 0, MW'('hA)));
    tbl.push_back(mkv(mk(1, 0, 1, '0, 1),       1, 0, 0, 4, '0));
    tbl.push_back(mkv(mk(1, 0, 1, '0, 1),       1, 1, 1, 1, MW'('hB)));
    tbl.push_back(mkv(mk(1, 0, 1, '0, 1),       1, 0, 0, 4, '0));
    tbl.push_back(mkv(mk(1, 0, 1, '0, 1),       1, 1, 1, 2, MW'('hC)));
    tbl.push_back(mkv(mk(1, 0, 1, '0, 1),       1, 0, 0, 4, '0));
    tbl.push_back(mkv(mk(1, 0, 1, '0, 1),       1, 1, 1, 3, MW'('hD)));
    tbl.push_back(mkv(mk(1, 0, 1, '0, 1),       1, 0, 0, 4, '0));
    tbl.push_back(mkv(mk(1, 0, 1, '0, 1),       1, 0, 1, 4, '0));

    // First cycle of reset on both instances; nothing is compared yet.
    step(mk(0, 1, 1, MW'('hA), 0), mk(0, 1, 1, '0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].s, idle);
      check($sformatf("tbl%0d.in_rdy", i), 64'(oa.in_rdy), 64'(tbl[i].in_rdy));
      check($sformatf("tbl%0d.deq_val", i), 64'(oa.deq_val), 64'(tbl[i].deq_val));
      check($sformatf("tbl%0d.cur_sd", i), 64'(oa.cur_sd), 64'(tbl[i].cur_sd));
      check($sformatf("tbl%0d.num_free", i), 64'(oa.num_free), 64'(tbl[i].num_free));
      if (tbl[i].deq_val)
        check($sformatf("tbl%0d.deq_msg", i), 64'(oa.msg), 64'(tbl[i].msg));
    end

    // Full boundary on domain 0 of the 3-domain instance.
    for (int i = 0; i < 4; i++) step(idle, mk(1, 1, 0, MW'(256 + i), 0));
    align_b(idle, idle);
    step(idle, mk(1, 1, 0, MW'('h1FF), 1));
    check("full.in_rdy", 64'(ob.in_rdy), 64'(0));
    check("full.deq_val", 64'(ob.deq_val), 64'(1));
    check("full.num_free", 64'(ob.num_free), 64'(0));
    check("full.deq_msg", 64'(ob.msg), 64'(256));
    step(idle, idle);
    check("full.next_num_free", 64'(ob.num_free), 64'(1));
    check("full.next_cur_sd", 64'(ob.cur_sd), 64'(0));

    // Slot rotation with dead window; every domain holds at least 3 messages.
    for (int i = 0; i < 4; i++) begin
      step(idle, mk(1, 1, 1, MW'(512 + i), 0));
      step(idle, mk(1, 1, 2, MW'(768 + i), 0));
    end
    align_b(idle, idle);
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      step(idle, mk(1, 0, 0, '0, 1));
      check($sformatf("slot%0d.cur_sd", i), 64'(ob.cur_sd), 64'(i / 4));
      check($sformatf("slot%0d.slot_last", i), 64'(ob.slot_last), 64'(i % 4 == 3));
      check($sformatf("slot%0d.deq_val", i), 64'(ob.deq_val), 64'(i % 4 != 3));
      if (ob.deq_val) pops++;
    end
    check("slot.pops", 64'(pops), 64'(9));
    step(idle, idle);
    check("slot.wrap_cur_sd", 64'(ob.cur_sd), 64'(0));

    // Out-of-range domain is refused.
    step(idle, mk(1, 1, 3, MW'('h5A), 0));
    check("oor.in_rdy", 64'(ob.in_rdy), 64'(0));

    // Reset mid-operation discards queued traffic.
    step(idle, mk(1, 1, 1, MW'('h400), 0));
    step(idle, mk(1, 1, 1, MW'('h401), 0));
    step(idle, mk(0, 0, 0, '0, 0));
    for (int i = 0; i < 12; i++) begin
      step(idle, mk(1, 0, 0, '0, 1));
      check($sformatf("rst%0d.deq_val", i), 64'(ob.deq_val), 64'(0));
    end

    // Random traffic on both instances against the model.
    for (int i = 0; i < 800; i++) step(rnd(), rnd());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
